// File: rtl/vga_pkg.sv
// Shared 640x480@60 timing constants and pixel types for the VGA raster
// generator and the blocks that consume its counters.
//   VGA_*       : default timing values (pixels / lines)
//   CNT_W/ROW_W : counter and row-address widths
//   rgb_t       : 12-bit {r,g,b} colour, 4 bits per channel
//   in_window() : true when pos lies in [start, start+len)
package vga_pkg;

  localparam int unsigned VGA_H_SYNC_END  = 95;
  localparam int unsigned VGA_H_ACT_START = 143;
  localparam int unsigned VGA_H_ACTIVE    = 640;
  localparam int unsigned VGA_H_TOTAL     = 800;
  localparam int unsigned VGA_V_SYNC_END  = 1;
  localparam int unsigned VGA_V_ACT_START = 35;
  localparam int unsigned VGA_V_ACTIVE    = 480;
  localparam int unsigned VGA_V_TOTAL     = 525;

  localparam int unsigned CNT_W = 10;
  localparam int unsigned ROW_W = 9;

  typedef struct packed {
    logic [3:0] r;
    logic [3:0] g;
    logic [3:0] b;
  } rgb_t;

  localparam rgb_t RGB_BLACK = '0;

  // Evaluated one bit wider so start+len cannot wrap.
  function automatic logic in_window(input logic [CNT_W-1:0] pos,
                                     input logic [CNT_W-1:0] start,
                                     input logic [CNT_W-1:0] len);
    logic [CNT_W:0] p, s, e;
    p = {1'b0, pos};
    s = {1'b0, start};
    e = s + {1'b0, len};
    return (p >= s) && (p < e);
  endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// Signal bundle between the VGA timing generator and its consumers
// (pixel overlay upstream of d_in, board VGA pins downstream).
//   master : timing generator side (drives counters, strobes, pins)
//   slave  : consumer side (supplies d_in, observes the rest)
interface vga_timing_gen_if;

  logic [11:0] d_in;
  logic [9:0]  h_count;
  logic [9:0]  v_count;
  logic        pix_stb;
  logic [8:0]  row_addr;
  logic [9:0]  col_addr;
  logic        rdn;
  logic        hs;
  logic        vs;
  logic [3:0]  r;
  logic [3:0]  g;
  logic [3:0]  b;
  logic        frame_start;

  modport master (
    input  d_in,
    output h_count, v_count, pix_stb, row_addr, col_addr,
    output rdn, hs, vs, r, g, b, frame_start
  );

  modport slave (
    output d_in,
    input  h_count, v_count, pix_stb, row_addr, col_addr,
    input  rdn, hs, vs, r, g, b, frame_start
  );

endinterface

// File: rtl/vga_pix_stb.sv
// Pixel-clock enable: divides the system clock by CLK_DIV and produces a
// one-clock pix_stb on the last count of each period.
//   clk     : system clock
//   rst_n   : asynchronous active-low reset
//   pix_stb : high while div_cnt == CLK_DIV-1 (constantly high for CLK_DIV=1)
module vga_pix_stb #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic pix_stb
);

  localparam int unsigned DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  if (CLK_DIV < 1 || CLK_DIV > 16) begin : g_bad_div
    $error("vga_pix_stb: CLK_DIV must be in 1..16");
  end

  logic [DW-1:0] div_cnt_q;
  logic [DW-1:0] div_cnt_d;

  always_comb begin
    pix_stb = (div_cnt_q == DIV_LAST);
  end

  always_comb begin
    div_cnt_d = div_cnt_q + 1'b1;
    if (pix_stb) begin
      div_cnt_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt_q <= '0;
    end else begin
      div_cnt_q <= div_cnt_d;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// 640x480@60 VGA raster timing generator.
// Counts pixels/lines on the divided pixel strobe, exposes the raw counters
// and active-window addresses to the overlay, and registers sync, blanking
// and colour into the VGA pins with one pixel of latency.
//   clk, rst_n      : system clock, asynchronous active-low reset
//   vga.d_in        : colour for the current h_count/v_count
//   vga.h_count/v_count, row_addr/col_addr : raster position
//   vga.pix_stb     : one-clock pixel strobe, counters advance on it
//   vga.frame_start : strobe on which counters wrap to (0,0)
//   vga.hs/vs/rdn/r/g/b : registered pin outputs (sync and rdn active low)
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int unsigned CLK_DIV     = 4,
  parameter int unsigned H_SYNC_END  = VGA_H_SYNC_END,
  parameter int unsigned H_ACT_START = VGA_H_ACT_START,
  parameter int unsigned H_ACTIVE    = VGA_H_ACTIVE,
  parameter int unsigned H_TOTAL     = VGA_H_TOTAL,
  parameter int unsigned V_SYNC_END  = VGA_V_SYNC_END,
  parameter int unsigned V_ACT_START = VGA_V_ACT_START,
  parameter int unsigned V_ACTIVE    = VGA_V_ACTIVE,
  parameter int unsigned V_TOTAL     = VGA_V_TOTAL
) (
  input  logic             clk,
  input  logic             rst_n,
  vga_timing_gen_if.master vga
);

  localparam logic [CNT_W-1:0] H_LAST      = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST      = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_LAST = CNT_W'(H_SYNC_END);
  localparam logic [CNT_W-1:0] V_SYNC_LAST = CNT_W'(V_SYNC_END);
  localparam logic [CNT_W-1:0] H_ACT_FIRST = CNT_W'(H_ACT_START);
  localparam logic [CNT_W-1:0] V_ACT_FIRST = CNT_W'(V_ACT_START);
  localparam logic [CNT_W-1:0] H_ACT_LEN   = CNT_W'(H_ACTIVE);
  localparam logic [CNT_W-1:0] V_ACT_LEN   = CNT_W'(V_ACTIVE);

  logic pix_stb;

  vga_pix_stb #(
    .CLK_DIV (CLK_DIV)
  ) u_pix_stb (
    .clk     (clk),
    .rst_n   (rst_n),
    .pix_stb (pix_stb)
  );

  logic [CNT_W-1:0] h_count_q, h_count_d;
  logic [CNT_W-1:0] v_count_q, v_count_d;
  logic             hs_q, hs_d;
  logic             vs_q, vs_d;
  logic             rdn_q, rdn_d;
  rgb_t             rgb_q, rgb_d;
  logic             h_wrap;
  logic             v_wrap;
  logic             active;

  always_comb begin
    h_wrap = (h_count_q == H_LAST);
    v_wrap = (v_count_q == V_LAST);
    active = in_window(h_count_q, H_ACT_FIRST, H_ACT_LEN) &&
             in_window(v_count_q, V_ACT_FIRST, V_ACT_LEN);
  end

  // Pin outputs describe the pixel at the counters before this strobe.
  always_comb begin
    h_count_d = h_count_q;
    v_count_d = v_count_q;
    hs_d      = hs_q;
    vs_d      = vs_q;
    rdn_d     = rdn_q;
    rgb_d     = rgb_q;
    if (pix_stb) begin
      h_count_d = h_wrap ? '0 : h_count_q + 1'b1;
      if (h_wrap) begin
        v_count_d = v_wrap ? '0 : v_count_q + 1'b1;
      end
      hs_d  = ~(h_count_q <= H_SYNC_LAST);
      vs_d  = ~(v_count_q <= V_SYNC_LAST);
      rdn_d = ~active;
      rgb_d = active ? rgb_t'(vga.d_in) : RGB_BLACK;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      h_count_q <= '0;
      v_count_q <= '0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      rdn_q     <= 1'b1;
      rgb_q     <= RGB_BLACK;
    end else begin
      h_count_q <= h_count_d;
      v_count_q <= v_count_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      rdn_q     <= rdn_d;
      rgb_q     <= rgb_d;
    end
  end

  assign vga.h_count     = h_count_q;
  assign vga.v_count     = v_count_q;
  assign vga.pix_stb     = pix_stb;
  assign vga.col_addr    = h_count_q - H_ACT_FIRST;
  assign vga.row_addr    = ROW_W'(v_count_q - V_ACT_FIRST);
  assign vga.frame_start = pix_stb & h_wrap & v_wrap;
  assign vga.hs          = hs_q;
  assign vga.vs          = vs_q;
  assign vga.rdn         = rdn_q;
  assign vga.r           = rgb_q.r;
  assign vga.g           = rgb_q.g;
  assign vga.b           = rgb_q.b;

endmodule

// File: tb/tb_vga_timing_gen.sv
module tb_vga_timing_gen;

  // Scaled-down timing for the randomized model run.
  localparam int D1   = 3;
  localparam int H1SE = 3;
  localparam int H1AS = 6;
  localparam int H1AL = 10;
  localparam int H1T  = 20;
  localparam int V1SE = 1;
  localparam int V1AS = 3;
  localparam int V1AL = 5;
  localparam int V1T  = 12;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst0_n;
  logic rst_n;

  vga_timing_gen_if v0 ();
  vga_timing_gen_if v1 ();
  vga_timing_gen_if v2 ();

  vga_timing_gen #(.CLK_DIV(4)) dut0 (
    .clk(clk), .rst_n(rst0_n), .vga(v0)
  );

  vga_timing_gen #(
    .CLK_DIV(D1), .H_SYNC_END(H1SE), .H_ACT_START(H1AS), .H_ACTIVE(H1AL),
    .H_TOTAL(H1T), .V_SYNC_END(V1SE), .V_ACT_START(V1AS), .V_ACTIVE(V1AL),
    .V_TOTAL(V1T)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .vga(v1)
  );

  vga_timing_gen #(.CLK_DIV(1)) dut2 (
    .clk(clk), .rst_n(rst_n), .vga(v2)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // Consume n pixel strobes of dut0; starts and ends at a negedge.
  task automatic adv0(input int n);
    for (int i = 0; i < n; i++) begin
      int t = 0;
      while (v0.pix_stb !== 1'b1 && t < 16) begin
        @(negedge clk);
        t++;
      end
      if (t >= 16) begin
        check("dut0 strobe timeout", 64'd0, 64'd1);
        return;
      end
      @(negedge clk);
    end
  endtask

  // Called at the negedge where reset is released (cycle 1).
  task automatic first_stb_seq(input string tag);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("%s first stb cyc%0d", tag, i + 1), 64'(v0.pix_stb), 64'(i == 3));
      if (i < 3) @(negedge clk);
    end
  endtask

  function automatic logic [63:0] pins0();
    return 64'({v0.h_count, v0.v_count, v0.hs, v0.vs, v0.rdn, v0.r, v0.g, v0.b});
  endfunction

  function automatic logic [63:0] rst_state0();
    return 64'({v0.h_count, v0.v_count, v0.hs, v0.vs, v0.rdn, v0.r, v0.g, v0.b,
                v0.pix_stb, v0.frame_start});
  endfunction

  function automatic logic [63:0] rst_expect();
    return 64'({10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 12'h000, 1'b0, 1'b0});
  endfunction

  typedef struct {
    int          k;    // cumulative strobes since reset release
    logic [11:0] d;
    logic [9:0]  h;
    logic [9:0]  v;
    logic        hs;
    logic        vs;
    logic        rdn;
    logic [11:0] rgb;
  } vec_t;

  vec_t tbl[9];

  // Model state for dut1/dut2.
  int          c;
  int          n, h, v, p, ph, pv;
  bit          stb, act, pact;
  logic [11:0] d1_last;
  logic [11:0] d1_now;
  int          stb_low;

  initial begin
    tbl[0] = '{0,    12'h123, 10'd0,   10'd0, 1'b1, 1'b1, 1'b1, 12'h000};
    tbl[1] = '{1,    12'hFFF, 10'd1,   10'd0, 1'b0, 1'b0, 1'b1, 12'h000};
    tbl[2] = '{96,   12'hABC, 10'd96,  10'd0, 1'b0, 1'b0, 1'b1, 12'h000};
    tbl[3] = '{97,   12'h0F0, 10'd97,  10'd0, 1'b1, 1'b0, 1'b1, 12'h000};
    tbl[4] = '{799,  12'hF00, 10'd799, 10'd0, 1'b1, 1'b0, 1'b1, 12'h000};
    tbl[5] = '{800,  12'h00F, 10'd0,   10'd1, 1'b1, 1'b0, 1'b1, 12'h000};
    tbl[6] = '{801,  12'h555, 10'd1,   10'd1, 1'b0, 1'b0, 1'b1, 12'h000};
    tbl[7] = '{1600, 12'hAAA, 10'd0,   10'd2, 1'b1, 1'b0, 1'b1, 12'h000};
    tbl[8] = '{1601, 12'h777, 10'd1,   10'd2, 1'b0, 1'b1, 1'b1, 12'h000};

    rst0_n  = 1'b0;
    rst_n   = 1'b0;
    v0.d_in = '0;
    v1.d_in = '0;
    v2.d_in = 12'hF00;
    repeat (3) @(negedge clk);

    // ---- dut0: default timing, CLK_DIV=4 ----
    check("dut0 reset state", rst_state0(), rst_expect());
    rst0_n = 1'b1;
    first_stb_seq("dut0");

    begin
      int cur = 0;
      foreach (tbl[i]) begin
        v0.d_in = tbl[i].d;
        adv0(tbl[i].k - cur);
        cur = tbl[i].k;
        check($sformatf("dut0 vec%0d k=%0d", i, tbl[i].k), pins0(),
              64'({tbl[i].h, tbl[i].v, tbl[i].hs, tbl[i].vs, tbl[i].rdn, tbl[i].rgb}));
      end
    end

    begin
      int lows = 0;
      for (int i = 0; i < 800; i++) begin
        adv0(1);
        if (v0.hs === 1'b0) lows++;
      end
      check("dut0 hs low strobes per line", 64'(lows), 64'd96);
    end

    // Now at h=1, v=3. Move to h=400 and reset mid-divider.
    adv0(399);
    check("dut0 pos before reset", 64'({v0.h_count, v0.v_count}), 64'({10'd400, 10'd3}));
    @(negedge clk);
    #2 rst0_n = 1'b0;
    #1 check("dut0 async reset h400", rst_state0(), rst_expect());
    @(negedge clk);
    rst0_n = 1'b1;
    first_stb_seq("dut0 rel1");
    adv0(50);
    check("dut0 in sync before reset2", pins0(),
          64'({10'd50, 10'd0, 1'b0, 1'b0, 1'b1, 12'h000}));
    @(negedge clk);
    @(negedge clk);
    #2 rst0_n = 1'b0;
    #1 check("dut0 async reset in sync", rst_state0(), rst_expect());
    @(negedge clk);
    rst0_n = 1'b1;
    first_stb_seq("dut0 rel2");
    adv0(1);
    check("dut0 sync line after reset", pins0(),
          64'({10'd1, 10'd0, 1'b0, 1'b0, 1'b1, 12'h000}));

    // ---- dut1 (random, model) and dut2 (CLK_DIV=1 default timing) ----
    check("dut2 reset state",
          64'({v2.h_count, v2.v_count, v2.hs, v2.vs, v2.rdn, v2.r, v2.g, v2.b}),
          64'({10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 12'h000}));
    rst_n   = 1'b1;
    c       = 0;
    d1_last = '0;
    stb_low = 0;
    while (c <= 28790) begin
      if (c < 1500) begin
        n   = c / D1;
        stb = (c % D1) == D1 - 1;
        h   = n % H1T;
        v   = (n / H1T) % V1T;
        act = (h >= H1AS) && (h < H1AS + H1AL) && (v >= V1AS) && (v < V1AS + V1AL);
        if (n == 0) begin
          check($sformatf("dut1 c=%0d", c),
                64'({v1.pix_stb, v1.frame_start, v1.h_count, v1.v_count,
                     v1.hs, v1.vs, v1.rdn, v1.r, v1.g, v1.b}),
                64'({stb, 1'b0, 10'(h), 10'(v), 1'b1, 1'b1, 1'b1, 12'h000}));
        end else begin
          p    = n - 1;
          ph   = p % H1T;
          pv   = (p / H1T) % V1T;
          pact = (ph >= H1AS) && (ph < H1AS + H1AL) && (pv >= V1AS) && (pv < V1AS + V1AL);
          check($sformatf("dut1 c=%0d", c),
                64'({v1.pix_stb, v1.frame_start, v1.h_count, v1.v_count,
                     v1.hs, v1.vs, v1.rdn, v1.r, v1.g, v1.b}),
                64'({stb, stb && h == H1T - 1 && v == V1T - 1, 10'(h), 10'(v),
                     !(ph <= H1SE), !(pv <= V1SE), !pact,
                     pact ? d1_last : 12'h000}));
        end
        if (act) begin
          check($sformatf("dut1 addr c=%0d", c),
                64'({v1.col_addr, v1.row_addr}),
                64'({10'(h - H1AS), 9'(v - V1AS)}));
        end
        d1_now  = 12'($urandom);
        v1.d_in = d1_now;
        if (stb) d1_last = d1_now;
      end

      if (v2.pix_stb !== 1'b1) stb_low++;
      case (c)
        799:   check("dut2 end of line0", 64'({v2.h_count, v2.v_count}), 64'({10'd799, 10'd0}));
        800:   check("dut2 line is 800 clk", 64'({v2.h_count, v2.v_count}), 64'({10'd0, 10'd1}));
        28001: check("dut2 syncs line35", 64'({v2.hs, v2.vs}), 64'({1'b0, 1'b1}));
        28143: check("dut2 first active addr",
                     64'({v2.h_count, v2.v_count, v2.col_addr, v2.row_addr, v2.rdn}),
                     64'({10'd143, 10'd35, 10'd0, 9'd0, 1'b1}));
        28144: check("dut2 first active pixel", 64'({v2.rdn, v2.r, v2.g, v2.b}),
                     64'({1'b0, 12'hF00}));
        28782: check("dut2 last col addr",
                     64'({v2.h_count, v2.col_addr, v2.row_addr}),
                     64'({10'd782, 10'd639, 9'd0}));
        28783: check("dut2 last active pixel", 64'({v2.rdn, v2.r, v2.g, v2.b}),
                     64'({1'b0, 12'hF00}));
        28784: check("dut2 blank after line", 64'({v2.rdn, v2.r, v2.g, v2.b}),
                     64'({1'b1, 12'h000}));
        default: ;
      endcase

      @(negedge clk);
      c++;
    end
    check("dut2 pix_stb always high", 64'(stb_low), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
